// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef logic [2:0] rx_state_t;
  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  typedef logic [1:0] tx_state_t;
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_transceiver_if.sv
// Byte-level port bundle between the UART and the keyboard/display adapters.
interface uart_transceiver_if;
  import uart_pkg::*;

  // RX: rx_flag holds rx_data until a one-cycle rx_ack strobe.
  // TX: tx_wr is taken only in a cycle where tx_flag = 1; otherwise it is dropped.
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_flag;
  logic                 rx_ack;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_flag;
  logic                 tx_wr;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  rx_state_t            rx_state;
  tx_state_t            tx_state;

  modport master (
    input  rx_data, rx_flag, tx_flag, rx_frame_err, rx_overrun, rx_state, tx_state,
    output rx_ack, tx_data, tx_wr
  );

  modport slave (
    output rx_data, rx_flag, tx_flag, rx_frame_err, rx_overrun, rx_state, tx_state,
    input  rx_ack, tx_data, tx_wr
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half,
  output logic tc
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  // A load of N-1 makes tc fire on the N-th cycle after the loading edge.
  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= half ? HALF_LOAD : FULL_LOAD;
    else if (cnt != '0)    cnt <= cnt - CW'(1);
  end

  assign tc = (cnt == '0);
endmodule

// File: rtl/uart_transceiver.sv
// 8N1 full-duplex UART: independent RX and TX state machines sharing one clock.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic eclk,
  input  logic ereset_n,
  input  logic rxd,
  output logic txd,
  uart_transceiver_if.slave bus
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rxd_s;

  always_ff @(posedge eclk) begin
    if (!ereset_n) sync <= '1;
    else           sync <= {sync[SYNC_STAGES-2:0], rxd};
  end
  assign rxd_s = sync[SYNC_STAGES-1];

  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_sh, rx_data_r;
  logic [2:0]           rx_idx;
  logic                 rx_flag_r, rx_ferr_r, rx_ovr_r;
  logic                 rx_load, rx_half, rx_tc, rx_done, rx_bad;

  always_comb begin
    rx_load = 1'b0;
    rx_half = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rxd_s) begin rx_load = 1'b1; rx_half = 1'b1; end
      RX_START: if (rx_tc && !rxd_s) rx_load = 1'b1;
      RX_DATA:  if (rx_tc) rx_load = 1'b1;
      default:  ;
    endcase
  end

  assign rx_done = (rx_state == RX_STOP) && rx_tc && rxd_s;
  assign rx_bad  = (rx_state == RX_STOP) && rx_tc && !rxd_s;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk(eclk), .rst_n(ereset_n), .load(rx_load), .half(rx_half), .tc(rx_tc)
  );

  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      rx_state  <= RX_IDLE;
      rx_sh     <= '0;
      rx_idx    <= '0;
      rx_data_r <= '0;
      rx_flag_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      rx_ovr_r  <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE:  if (!rxd_s) rx_state <= RX_START;
        RX_START: if (rx_tc) begin
          rx_state <= rxd_s ? RX_IDLE : RX_DATA;
          rx_idx   <= '0;
        end
        RX_DATA:  if (rx_tc) begin
          rx_sh  <= {rxd_s, rx_sh[DATA_BITS-1:1]};
          rx_idx <= rx_idx + 3'd1;
          if (rx_idx == LAST_BIT) rx_state <= RX_STOP;
        end
        RX_STOP:  if (rx_tc) rx_state <= rxd_s ? RX_IDLE : RX_BREAK;
        RX_BREAK: if (rxd_s) rx_state <= RX_IDLE;
        default:  rx_state <= RX_IDLE;
      endcase

      // A completing byte overrides a same-cycle ack, so the new byte stays flagged.
      if (bus.rx_ack) begin
        rx_flag_r <= 1'b0;
        rx_ferr_r <= 1'b0;
        rx_ovr_r  <= 1'b0;
      end
      if (rx_done) begin
        rx_data_r <= rx_sh;
        rx_flag_r <= 1'b1;
        if (rx_flag_r && !bus.rx_ack) rx_ovr_r <= 1'b1;
      end
      if (rx_bad) rx_ferr_r <= 1'b1;
    end
  end

  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_sh;
  logic [2:0]           tx_idx;
  logic                 txd_r, tx_accept, tx_load, tx_tc;

  assign tx_accept = (tx_state == TX_IDLE) && bus.tx_wr;
  assign tx_load   = tx_accept ||
                     (tx_tc && (tx_state == TX_START || tx_state == TX_DATA));

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk(eclk), .rst_n(ereset_n), .load(tx_load), .half(1'b0), .tc(tx_tc)
  );

  // txd is registered so the line never glitches between bit periods.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      tx_state <= TX_IDLE;
      tx_sh    <= '0;
      tx_idx   <= '0;
      txd_r    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE:  if (bus.tx_wr) begin
          tx_sh    <= bus.tx_data;
          txd_r    <= 1'b0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_tc) begin
          txd_r    <= tx_sh[0];
          tx_sh    <= {1'b0, tx_sh[DATA_BITS-1:1]};
          tx_idx   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA:  if (tx_tc) begin
          if (tx_idx == LAST_BIT) begin
            txd_r    <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            txd_r  <= tx_sh[0];
            tx_sh  <= {1'b0, tx_sh[DATA_BITS-1:1]};
            tx_idx <= tx_idx + 3'd1;
          end
        end
        TX_STOP:  if (tx_tc) tx_state <= TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd              = txd_r;
  assign bus.tx_flag      = (tx_state == TX_IDLE);
  assign bus.rx_data      = rx_data_r;
  assign bus.rx_flag      = rx_flag_r;
  assign bus.rx_frame_err = rx_ferr_r;
  assign bus.rx_overrun   = rx_ovr_r;
  assign bus.rx_state     = rx_state;
  assign bus.tx_state     = tx_state;
endmodule
